// File: rtl/fma16_pkg.sv
// Shared definitions for the binary16 operand unpacker.
// Holds the FSM state encoding, the field widths, the exponent constants
// and the registered result payload type.
package fma16_pkg;

    localparam int unsigned FRAC_W  = 10;
    localparam int unsigned EXPF_W  = 5;
    localparam int unsigned X_W     = 16;
    localparam int unsigned EXP_W   = 7;
    localparam int unsigned MANT_W  = FRAC_W + 1;
    localparam int unsigned BIAS    = 15;
    localparam int unsigned EXP_MAX = 31;

    // Unbiased exponent of a subnormal before normalization (1 - BIAS = -14)
    localparam logic [EXP_W-1:0] E_SUB_INIT = 7'h72;
    // Exponent reported for Inf/NaN (EXP_MAX - BIAS)
    localparam logic [EXP_W-1:0] E_SPECIAL  = 7'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              s;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic              zero;
        logic              sub;
        logic              inf;
        logic              nan;
        logic              snan;
    } result_t;

endpackage

// File: rtl/fma16_unpack.sv
// Unpacks a binary16 operand into sign, unbiased two's-complement exponent,
// normalized 11-bit mantissa and class flags. Subnormals are normalized by
// an iterative one-bit-per-cycle shifter.
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   in_valid/in_ready/in_x operand handshake, in_ready high only in IDLE
//   out_valid/out_ready    result handshake, result held while stalled
//   out_s/out_e/out_m      sign, exponent (7b signed), mantissa (bit 10 = leading one)
//   out_zero/sub/inf/nan/snan classification flags
module fma16_unpack
    import fma16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [X_W-1:0]    in_x,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [EXP_W-1:0]  out_e,
    output logic [MANT_W-1:0] out_m,
    output logic              out_zero,
    output logic              out_sub,
    output logic              out_inf,
    output logic              out_nan,
    output logic              out_snan
);

    state_t  state, state_next;
    result_t res, res_next;

    logic [EXPF_W-1:0] x_exp;
    logic [FRAC_W-1:0] x_frac;

    assign x_exp  = in_x[X_W-2 -: EXPF_W];
    assign x_frac = in_x[FRAC_W-1:0];

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        res_next   = res;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    res_next   = '0;
                    res_next.s = in_x[X_W-1];
                    if (x_exp == '0 && x_frac == '0) begin
                        res_next.zero = 1'b1;
                        state_next    = DONE;
                    end else if (x_exp == '0) begin
                        res_next.sub = 1'b1;
                        res_next.m   = {1'b0, x_frac};
                        res_next.e   = E_SUB_INIT;
                        state_next   = NORM;
                    end else if (x_exp == EXPF_W'(EXP_MAX)) begin
                        res_next.m    = {1'b1, x_frac};
                        res_next.e    = E_SPECIAL;
                        res_next.inf  = (x_frac == '0);
                        res_next.nan  = (x_frac != '0);
                        res_next.snan = (x_frac != '0) && !x_frac[FRAC_W-1];
                        state_next    = DONE;
                    end else begin
                        res_next.m = {1'b1, x_frac};
                        res_next.e = EXP_W'({2'b00, x_exp}) - EXP_W'(BIAS);
                        state_next = DONE;
                    end
                end
            end
            NORM: begin
                res_next.m = {res.m[MANT_W-2:0], 1'b0};
                res_next.e = res.e - EXP_W'(1);
                // Finish when the bit being shifted into position 10 is the leading one
                if (res.m[MANT_W-2]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, result and handshake registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            res       <= res_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    assign out_s    = res.s;
    assign out_e    = res.e;
    assign out_m    = res.m;
    assign out_zero = res.zero;
    assign out_sub  = res.sub;
    assign out_inf  = res.inf;
    assign out_nan  = res.nan;
    assign out_snan = res.snan;

endmodule

// File: tb/tb_fma16_unpack.sv
// Self-checking bench for fma16_unpack: table of operands with expected
// unpacked results and latency, scoreboard queue, plus stall and
// mid-normalization reset sequences.
module tb_fma16_unpack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_x;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [6:0]  out_e;
    logic [10:0] out_m;
    logic        out_zero, out_sub, out_inf, out_nan, out_snan;

    always #5 clk = ~clk;

    fma16_unpack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_m     (out_m),
        .out_zero  (out_zero),
        .out_sub   (out_sub),
        .out_inf   (out_inf),
        .out_nan   (out_nan),
        .out_snan  (out_snan)
    );

    // flags packed as {zero, sub, inf, nan, snan}
    typedef struct {
        logic [15:0] x;
        logic        s;
        logic [6:0]  e;
        logic [10:0] m;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [4:0] flags();
        return {out_zero, out_sub, out_inf, out_nan, out_snan};
    endfunction

    // Drive one operand, wait for the result, compare against the scoreboard
    task automatic apply(input vec_t v, input int hold);
        vec_t e;
        int   cyc;
        bit   busy_ok;
        @(negedge clk);
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_x      = v.x;
        out_ready = (hold == 0);
        sb.push_back(v);
        @(negedge clk);
        in_x    = 16'hFFFF;
        in_valid = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 20) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'b1;   // must be ignored while busy
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (v.lat > 1) chk("busy_ready_low", 32'(busy_ok), 32'd1);
        chk("latency", 32'(cyc), 32'(v.lat));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_s", 32'(out_s), 32'(e.s));
            chk("out_e", 32'(out_e), 32'(e.e));
            chk("out_m", 32'(out_m), 32'(e.m));
            chk("flags", 32'(flags()), 32'(e.f));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                in_x     = 16'h0001;
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_ready", 32'(in_ready), 32'd0);
                chk("hold_e", 32'(out_e), 32'(e.e));
                chk("hold_m", 32'(out_m), 32'(e.m));
                chk("hold_flags", 32'(flags()), 32'(e.f));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit quiet;

        //           x         s     e      m        f          lat
        vecs[0]  = '{16'h3C00, 1'b0, 7'h00, 11'h400, 5'b00000, 1};
        vecs[1]  = '{16'h0001, 1'b0, 7'h68, 11'h400, 5'b01000, 11};
        vecs[2]  = '{16'h8200, 1'b1, 7'h71, 11'h400, 5'b01000, 2};
        vecs[3]  = '{16'h7C00, 1'b0, 7'h10, 11'h400, 5'b00100, 1};
        vecs[4]  = '{16'h7E00, 1'b0, 7'h10, 11'h600, 5'b00010, 1};
        vecs[5]  = '{16'h7D00, 1'b0, 7'h10, 11'h500, 5'b00011, 1};
        vecs[6]  = '{16'h8000, 1'b1, 7'h00, 11'h000, 5'b10000, 1};
        vecs[7]  = '{16'h7BFF, 1'b0, 7'h0F, 11'h7FF, 5'b00000, 1};
        vecs[8]  = '{16'h0400, 1'b0, 7'h72, 11'h400, 5'b00000, 1};
        vecs[9]  = '{16'h03FF, 1'b0, 7'h71, 11'h7FE, 5'b01000, 2};
        vecs[10] = '{16'hFE01, 1'b1, 7'h10, 11'h601, 5'b00010, 1};
        vecs[11] = '{16'h0040, 1'b0, 7'h6E, 11'h400, 5'b01000, 5};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = 16'h0000;
        out_ready = 1'b1;
        #1;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_outs", 32'({out_s, out_e, out_m, flags()}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i], 0);
        end

        // Stalled consumer: result must hold for 5 cycles
        apply('{16'h5640, 1'b0, 7'h06, 11'h640, 5'b00000, 1}, 5);

        // Reset during normalization abandons the operand
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_ready", 32'(in_ready), 32'd1);
        chk("midreset_valid", 32'(out_valid), 32'd0);
        chk("midreset_outs", 32'({out_s, out_e, out_m, flags()}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || !in_ready) quiet = 1'b0;
        end
        chk("no_partial_result", 32'(quiet), 32'd1);
        apply(vecs[0], 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
